// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the 5-stage MIPS core.
// Carries valid, instruction, PC, destination GPR, RegWrite and an opaque payload,
// with stall (hold) and flush (bubble) controls. The hazard-unit Tnew field is aged
// by a saturating decrement on every advance.
// Optional feature macro: PIPE_REG_KEEP_PC_EN -- when defined, a flush keeps pc_in
// in the bubble instead of loading PC_RST, so the bubble can still report its PC.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1,
    parameter logic [31:0] PC_RST   = 32'h3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic [4:0]        wreg_in,
    input  logic              regwrite_in,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic [4:0]        wreg_out,
    output logic              regwrite_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic              tnew_zero
);

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [31:0]       instr_q,    instr_d;
    logic [31:0]       pc_q,       pc_d;
    logic [4:0]        wreg_q,     wreg_d;
    logic              regwrite_q, regwrite_d;
    logic [TNEW_W-1:0] tnew_q,     tnew_d;

    logic [31:0]       tnewWide;
    logic [TNEW_W-1:0] tnewAged;
    logic [31:0]       bubblePc;

    // Tnew is compared at 32 bits so a decrement larger than the field still saturates at 0.
    always_comb begin
        tnewWide = 32'(tnew_in);
        tnewAged = '0;
        if (tnewWide > TNEW_DEC) begin
            tnewAged = TNEW_W'(tnewWide - TNEW_DEC);
        end
    end

`ifdef PIPE_REG_KEEP_PC_EN
    // The bubble keeps the upstream PC for later EPC / delay-slot reporting.
    assign bubblePc = pc_in;
`else
    // The bubble looks exactly like the reset state, PC included.
    assign bubblePc = PC_RST;
`endif

    // Next-state selection: flush beats stall, stall beats load; reset is applied in the flop.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        tnew_d     = tnew_q;
        if (flush) begin
            valid_d    = 1'b0;
            data_d     = '0;
            instr_d    = '0;
            pc_d       = bubblePc;
            wreg_d     = '0;
            regwrite_d = 1'b0;
            tnew_d     = '0;
        end else if (!stall) begin
            valid_d    = valid_in;
            data_d     = data_in;
            instr_d    = instr_in;
            pc_d       = pc_in;
            wreg_d     = valid_in ? wreg_in : 5'd0;
            regwrite_d = valid_in & regwrite_in;
            tnew_d     = tnewAged;
        end
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            instr_q    <= '0;
            pc_q       <= PC_RST;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            tnew_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            tnew_q     <= tnew_d;
        end
    end

    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign wreg_out     = wreg_q;
    assign regwrite_out = regwrite_q;
    assign tnew_out     = tnew_q;
    assign tnew_zero    = (tnew_q == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default parameters).
// Expected PC after a flush follows PIPE_REG_KEEP_PC_EN, matching the DUT build.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [63:0] data_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [4:0]  wreg_in;
    logic        regwrite_in;
    logic [1:0]  tnew_in;
    logic        valid_out;
    logic [63:0] data_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [4:0]  wreg_out;
    logic        regwrite_out;
    logic [1:0]  tnew_out;
    logic        tnew_zero;

    int checks;
    int failures;

    pipe_stage_reg dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .wreg_in      (wreg_in),
        .regwrite_in  (regwrite_in),
        .tnew_in      (tnew_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .wreg_out     (wreg_out),
        .regwrite_out (regwrite_out),
        .tnew_out     (tnew_out),
        .tnew_zero    (tnew_zero)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic v, input logic [63:0] d, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [4:0] wr, input logic rw,
                              input logic [1:0] tn);
        valid_in    = v;
        data_in     = d;
        instr_in    = ins;
        pc_in       = pc;
        wreg_in     = wr;
        regwrite_in = rw;
        tnew_in     = tn;
    endtask

    task automatic test_reset();
        set_inputs(1'b1, {$urandom, $urandom}, $urandom, $urandom, 5'($urandom),
                   1'b1, 2'($urandom_range(1, 3)));
        stall = 1'($urandom);
        flush = 1'($urandom);
        reset = 1'b0;
        tick();
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", valid_out); end
        checks++; if (pc_out !== 32'h3000) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=00003000", pc_out); end
        checks++; if (tnew_out !== 2'd0) begin failures++; $display("[TB] FAIL reset_tnew got=%0d exp=0", tnew_out); end
        checks++; if (tnew_zero !== 1'b1) begin failures++; $display("[TB] FAIL reset_tnew_zero got=%0b exp=1", tnew_zero); end
        checks++; if (regwrite_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_regwrite got=%0b exp=0", regwrite_out); end
        checks++; if (wreg_out !== 5'd0) begin failures++; $display("[TB] FAIL reset_wreg got=%0d exp=0", wreg_out); end
        checks++; if (instr_out !== 32'd0 || data_out !== 64'd0) begin failures++; $display("[TB] FAIL reset_instr_data got=%h/%h exp=0/0", instr_out, data_out); end
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_advance();
        set_inputs(1'b1, 64'hDEAD_BEEF_0123_4567, 32'h2108_0004, 32'h3004, 5'd8, 1'b1, 2'd2);
        #1;
        checks++; if (valid_out !== 1'b0 || pc_out !== 32'h3000) begin failures++; $display("[TB] FAIL no_comb_path got valid=%0b pc=%h exp valid=0 pc=00003000", valid_out, pc_out); end
        tick();
        checks++; if (tnew_out !== 2'd1 || tnew_zero !== 1'b0) begin failures++; $display("[TB] FAIL adv_tnew got=%0d/%0b exp=1/0", tnew_out, tnew_zero); end
        checks++; if (wreg_out !== 5'd8 || regwrite_out !== 1'b1) begin failures++; $display("[TB] FAIL adv_wreg got=%0d/%0b exp=8/1", wreg_out, regwrite_out); end
        checks++; if (pc_out !== 32'h3004 || valid_out !== 1'b1) begin failures++; $display("[TB] FAIL adv_pc got=%h/%0b exp=00003004/1", pc_out, valid_out); end
        checks++; if (data_out !== 64'hDEAD_BEEF_0123_4567 || instr_out !== 32'h2108_0004) begin failures++; $display("[TB] FAIL adv_payload got=%h/%h exp=deadbeef01234567/21080004", data_out, instr_out); end
    endtask

    task automatic test_saturation();
        set_inputs(1'b1, 64'h1, 32'h0, 32'h3008, 5'd9, 1'b1, 2'd0);
        tick();
        checks++; if (tnew_out !== 2'd0 || tnew_zero !== 1'b1) begin failures++; $display("[TB] FAIL sat_tnew0 got=%0d/%0b exp=0/1", tnew_out, tnew_zero); end
        tnew_in = 2'd1;
        tick();
        checks++; if (tnew_out !== 2'd0) begin failures++; $display("[TB] FAIL sat_tnew1 got=%0d exp=0", tnew_out); end
        tnew_in = 2'd3;
        tick();
        checks++; if (tnew_out !== 2'd2) begin failures++; $display("[TB] FAIL sat_tnew3 got=%0d exp=2", tnew_out); end
    endtask

    task automatic test_stall();
        set_inputs(1'b1, 64'hAAAA, 32'h0128_5021, 32'h300C, 5'd10, 1'b1, 2'd3);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'($urandom), {$urandom, $urandom}, $urandom, $urandom, 5'($urandom),
                       1'($urandom), 2'($urandom));
            tick();
        end
        checks++; if (instr_out !== 32'h0128_5021) begin failures++; $display("[TB] FAIL stall_instr got=%h exp=01285021", instr_out); end
        checks++; if (tnew_out !== 2'd2) begin failures++; $display("[TB] FAIL stall_tnew got=%0d exp=2", tnew_out); end
        checks++; if (pc_out !== 32'h300C || wreg_out !== 5'd10 || data_out !== 64'hAAAA) begin failures++; $display("[TB] FAIL stall_hold got=%h/%0d/%h exp=0000300c/10/aaaa", pc_out, wreg_out, data_out); end
        stall = 1'b0;
    endtask

    task automatic test_flush_stall();
        logic [31:0] expPc;
`ifdef PIPE_REG_KEEP_PC_EN
        expPc = 32'h3010;
`else
        expPc = 32'h3000;
`endif
        set_inputs(1'b1, 64'h55, 32'h1234_5678, 32'h3010, 5'd12, 1'b1, 2'd3);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        checks++; if (valid_out !== 1'b0 || wreg_out !== 5'd0 || regwrite_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_bubble got=%0b/%0d/%0b exp=0/0/0", valid_out, wreg_out, regwrite_out); end
        checks++; if (pc_out !== expPc) begin failures++; $display("[TB] FAIL flush_pc got=%h exp=%h", pc_out, expPc); end
        checks++; if (instr_out !== 32'd0 || data_out !== 64'd0 || tnew_zero !== 1'b1) begin failures++; $display("[TB] FAIL flush_fields got=%h/%h/%0b exp=0/0/1", instr_out, data_out, tnew_zero); end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_invalid();
        set_inputs(1'b0, 64'h77, 32'h0, 32'h3014, 5'd31, 1'b1, 2'd2);
        tick();
        checks++; if (regwrite_out !== 1'b0 || wreg_out !== 5'd0) begin failures++; $display("[TB] FAIL invalid_gate got=%0b/%0d exp=0/0", regwrite_out, wreg_out); end
        checks++; if (valid_out !== 1'b0 || pc_out !== 32'h3014 || tnew_out !== 2'd1) begin failures++; $display("[TB] FAIL invalid_fields got=%0b/%h/%0d exp=0/00003014/1", valid_out, pc_out, tnew_out); end
    endtask

    task automatic test_back_to_back();
        set_inputs(1'b1, 64'h1, 32'h1, 32'h3018, 5'd1, 1'b1, 2'd3);
        tick();
        set_inputs(1'b1, 64'h2, 32'h2, 32'h301C, 5'd2, 1'b0, 2'd2);
        tick();
        checks++; if (pc_out !== 32'h301C || wreg_out !== 5'd2 || regwrite_out !== 1'b0 || tnew_out !== 2'd1) begin failures++; $display("[TB] FAIL b2b got=%h/%0d/%0b/%0d exp=0000301c/2/0/1", pc_out, wreg_out, regwrite_out, tnew_out); end
        stall = 1'b1;
        reset = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0 || pc_out !== 32'h3000 || tnew_out !== 2'd0) begin failures++; $display("[TB] FAIL reset_mid_stall got=%0b/%h/%0d exp=0/00003000/0", valid_out, pc_out, tnew_out); end
        stall = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        set_inputs(1'b0, 64'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
        #2;
        test_reset();
        test_advance();
        test_saturation();
        test_stall();
        test_flush_stall();
        test_invalid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
